// File: rtl/rv32_pkg.sv
// Shared RV32 constants: opcodes, immediate-format selects, NOP encoding and
// the fetch FSM state type.
package rv32_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DROP  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/imm_sel_decode.sv
// Opcode to immediate-format select; unknown opcodes map to IMM_NONE so
// immgen produces zero.
module imm_sel_decode
    import rv32_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [2:0] o_sel
);

    always_comb begin
        o_sel = IMM_NONE;
        case (i_opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: o_sel = IMM_I;
            OPC_STORE:                                  o_sel = IMM_S;
            OPC_BRANCH:                                 o_sel = IMM_B;
            OPC_LUI, OPC_AUIPC:                         o_sel = IMM_U;
            OPC_JAL:                                    o_sel = IMM_J;
            default:                                    o_sel = IMM_NONE;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding imem request and the IF/ID register.
// state | meaning
// BOOT  | first cycle out of reset, no request
// ISSUE | imem_req high, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid
// HOLD  | response parked in skid buffer while decode stalls
// DROP  | waiting out the response of a flushed request
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = RV32_NOP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_flush_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_id_valid,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_instr,
    output logic [2:0]  o_id_imm_sel,
    output logic [24:0] o_id_imm_data
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_skid;
    logic         r_imem_req;
    logic         r_id_valid;
    logic [31:0]  r_id_pc;
    logic [31:0]  r_id_instr;
    logic [2:0]   r_id_imm_sel;

    logic [31:0]  w_flush_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_load_instr;
    logic [2:0]   w_load_sel;
    logic         w_have_instr;

    assign w_flush_pc   = i_flush_target & 32'hFFFF_FFFC;
    assign w_pc_next    = r_pc + 32'd4;
    assign w_load_instr = (r_state == ST_HOLD) ? r_skid : i_imem_rdata;
    assign w_have_instr = (r_state == ST_HOLD) || ((r_state == ST_WAIT) && i_imem_rvalid);

    imm_sel_decode u_imm_sel_decode (
        .i_opcode (w_load_instr[6:0]),
        .o_sel    (w_load_sel)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_skid       <= '0;
            r_imem_req   <= 1'b0;
            r_id_valid   <= 1'b0;
            r_id_pc      <= RESET_PC;
            r_id_instr   <= NOP_INSTR;
            r_id_imm_sel <= IMM_I;
        end else if (i_flush) begin
            r_pc         <= w_flush_pc;
            r_id_valid   <= 1'b0;
            r_id_instr   <= NOP_INSTR;
            r_id_imm_sel <= IMM_I;
            case (r_state)
                ST_ISSUE: begin
                    // an accepted request still owes us a response that must be discarded
                    if (i_imem_ready) begin
                        r_state    <= ST_DROP;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_state    <= ST_ISSUE;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_WAIT, ST_DROP: begin
                    if (i_imem_rvalid) begin
                        r_state    <= ST_ISSUE;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_state    <= ST_DROP;
                        r_imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_ISSUE;
                    r_imem_req <= 1'b1;
                end
            endcase
        end else begin
            if (!i_stall) begin
                r_id_valid <= 1'b0;
            end
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_ISSUE;
                    r_imem_req <= 1'b1;
                end
                ST_ISSUE: begin
                    if (i_imem_ready) begin
                        r_state    <= ST_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                ST_WAIT, ST_HOLD: begin
                    if (w_have_instr && !i_stall) begin
                        r_id_valid   <= 1'b1;
                        r_id_pc      <= r_pc;
                        r_id_instr   <= w_load_instr;
                        r_id_imm_sel <= w_load_sel;
                        r_pc         <= w_pc_next;
                        r_state      <= ST_ISSUE;
                        r_imem_req   <= 1'b1;
                    end else if ((r_state == ST_WAIT) && i_imem_rvalid) begin
                        r_skid  <= i_imem_rdata;
                        r_state <= ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (i_imem_rvalid) begin
                        r_state    <= ST_ISSUE;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_id_valid    = r_id_valid;
    assign o_id_pc       = r_id_pc;
    assign o_id_instr    = r_id_instr;
    assign o_id_imm_sel  = r_id_imm_sel;
    assign o_id_imm_data = r_id_instr[31:7];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random memory timing,
// stalls and flushes checked against a transaction-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n_w = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_target = '0;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        req, req_w;
    logic [31:0] addr, addr_w;
    logic        id_valid, id_valid_w;
    logic [31:0] id_pc, id_pc_w, id_instr, id_instr_w;
    logic [2:0]  id_sel, id_sel_w;
    logic [24:0] id_imm, id_imm_w;

    int n_checks = 0;
    int n_errors = 0;
    int n_consumed = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pc;
    logic        mem_out, mem_drop, prev_flush;
    int          mem_cnt;
    logic [31:0] mem_data;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_flush_target(flush_target), .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_ready(imem_ready), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
        .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_instr(id_instr),
        .o_id_imm_sel(id_sel), .o_id_imm_data(id_imm)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_dut_w (
        .i_clk(clk), .i_rst_n(rst_n_w), .i_stall(stall), .i_flush(flush),
        .i_flush_target(flush_target), .o_imem_req(req_w), .o_imem_addr(addr_w),
        .i_imem_ready(imem_ready), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
        .o_id_valid(id_valid_w), .o_id_pc(id_pc_w), .o_id_instr(id_instr_w),
        .o_id_imm_sel(id_sel_w), .o_id_imm_data(id_imm_w)
    );

    function automatic logic [2:0] ref_sel(input logic [31:0] ins);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return 3'b000;
            7'h23:                      return 3'b001;
            7'h63:                      return 3'b010;
            7'h37, 7'h17:               return 3'b011;
            7'h6F:                      return 3'b100;
            default:                    return 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [0:10];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch of one word; entered and left at a negedge with the DUT in ISSUE.
    task automatic zw_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        chk("zw_req", 32'(req), 32'd1);
        chk("zw_addr", addr, exp_addr);
        @(negedge clk);
        chk("zw_wait_req", 32'(req), 32'd0);
        chk("zw_wait_valid", 32'(id_valid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("zw_id_valid", 32'(id_valid), 32'd1);
        chk("zw_id_pc", id_pc, exp_addr);
        chk("zw_id_instr", id_instr, data);
        chk("zw_id_sel", 32'(id_sel), 32'(ref_sel(data)));
        chk("zw_id_imm", 32'(id_imm), 32'(data >> 7));
    endtask

    task automatic rand_cycle(input bit quiet);
        exp_t e;
        stall        = quiet ? 1'b0 : ($urandom_range(0, 9) < 3);
        flush        = quiet ? 1'b0 : ($urandom_range(0, 15) == 0);
        flush_target = $urandom;
        imem_ready   = ($urandom_range(0, 9) < 7);
        imem_rvalid  = mem_out && (mem_cnt == 0);
        imem_rdata   = imem_rvalid ? mem_data : $urandom;
        chk("one_outstanding", 32'(req && mem_out), 32'd0);
        if (prev_flush) chk("flush_kills_id", 32'(id_valid), 32'd0);
        if (id_valid && !stall && !flush) begin
            n_consumed++;
            if (q.size() == 0) begin
                chk("id_unexpected", 32'(id_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("rnd_id_pc", id_pc, e.pc);
                chk("rnd_id_instr", id_instr, e.instr);
                chk("rnd_id_sel", 32'(id_sel), 32'(ref_sel(e.instr)));
                chk("rnd_id_imm", 32'(id_imm), 32'(e.instr >> 7));
            end
        end
        if (imem_rvalid) begin
            mem_out = 1'b0;
            if (!mem_drop && !flush) begin
                e.pc    = m_pc;
                e.instr = mem_data;
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end else if (mem_out) begin
            mem_cnt--;
        end
        if (req && imem_ready) begin
            chk("rnd_req_addr", addr, m_pc);
            mem_out  = 1'b1;
            mem_drop = 1'b0;
            mem_cnt  = $urandom_range(0, 2);
            mem_data = rand_instr();
        end
        if (flush) begin
            m_pc = flush_target & 32'hFFFF_FFFC;
            q.delete();
            if (mem_out) mem_drop = 1'b1;
        end
        prev_flush = flush;
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'h0000_0000);
        chk("rst_sel", 32'(id_sel), 32'd0);
        chk("rst_pc_w", id_pc_w, 32'hFFFF_FFFC);

        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        zw_fetch(32'h0000_0000, 32'h0000_0013);
        zw_fetch(32'h0000_0004, 32'h0010_0093);
        zw_fetch(32'h0000_0008, 32'h0020_0113);

        zw_fetch(32'h0000_000C, 32'h0000_0463);
        chk("beq_sel", 32'(id_sel), 32'd2);
        chk("beq_imm", 32'(id_imm), 32'h0000_0008);
        zw_fetch(32'h0000_0010, 32'h00A1_2223);
        chk("sw_sel", 32'(id_sel), 32'd1);
        zw_fetch(32'h0000_0014, 32'h0080_006F);
        chk("jal_sel", 32'(id_sel), 32'd4);
        zw_fetch(32'h0000_0018, 32'h0020_81B3);
        chk("add_sel", 32'(id_sel), 32'd7);

        // stall over the response: ID frozen, no request until released
        chk("st_addr", addr, 32'h0000_001C);
        @(negedge clk);
        stall = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0050_0093;
        @(negedge clk);
        imem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("st_req", 32'(req), 32'd0);
            chk("st_valid", 32'(id_valid), 32'd0);
            chk("st_pc", id_pc, 32'h0000_0018);
            chk("st_instr", id_instr, 32'h0020_81B3);
            if (i == 1) stall = 1'b0;
            @(negedge clk);
        end
        chk("skid_valid", 32'(id_valid), 32'd1);
        chk("skid_pc", id_pc, 32'h0000_001C);
        chk("skid_instr", id_instr, 32'h0050_0093);
        zw_fetch(32'h0000_0020, 32'h0000_0013);

        // flush while WAIT; late response is discarded
        chk("fl_addr", addr, 32'h0000_0024);
        @(negedge clk);
        flush = 1'b1;
        flush_target = 32'h0000_0102;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", 32'(id_valid), 32'd0);
        chk("fl_instr", id_instr, 32'h0000_0013);
        chk("fl_req", 32'(req), 32'd0);
        @(negedge clk);
        chk("fl_drop_req", 32'(req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("fl_after_valid", 32'(id_valid), 32'd0);
        chk("fl_after_addr", addr, 32'h0000_0100);
        zw_fetch(32'h0000_0100, 32'h00A1_2223);

        // memory not ready: request and address held
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nr_req", 32'(req), 32'd1);
            chk("nr_addr", addr, 32'h0000_0104);
        end
        imem_ready = 1'b1;
        zw_fetch(32'h0000_0104, 32'h0080_006F);

        // asynchronous reset mid-flight, then randomized traffic
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(id_valid), 32'd0);
        chk("mid_rst_addr", addr, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0;
        mem_out = 1'b0;
        mem_drop = 1'b0;
        mem_cnt = 0;
        mem_data = '0;
        prev_flush = 1'b0;
        q.delete();
        for (int i = 0; i < 2000; i++) rand_cycle(1'b0);
        for (int i = 0; i < 10; i++) rand_cycle(1'b1);
        chk("consumed_enough", 32'(n_consumed > 100), 32'd1);

        // wrapping reset PC and reset during WAIT with a stale response
        stall = 1'b0;
        flush = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready = 1'b1;
        rst_n_w = 1'b1;
        @(negedge clk);
        chk("w_req", 32'(req_w), 32'd1);
        chk("w_addr", addr_w, 32'hFFFF_FFFC);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0013;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("w_id_pc", id_pc_w, 32'hFFFF_FFFC);
        chk("w_id_valid", 32'(id_valid_w), 32'd1);
        chk("w_wrap_addr", addr_w, 32'h0000_0000);
        @(negedge clk);
        chk("w_wait_req", 32'(req_w), 32'd0);
        rst_n_w = 1'b0;
        #1;
        chk("w_rst_req", 32'(req_w), 32'd0);
        chk("w_rst_valid", 32'(id_valid_w), 32'd0);
        chk("w_rst_pc", id_pc_w, 32'hFFFF_FFFC);
        chk("w_rst_instr", id_instr_w, 32'h0000_0013);
        chk("w_rst_sel", 32'(id_sel_w), 32'd0);
        chk("w_rst_imm", 32'(id_imm_w), 32'h0000_0000);
        @(negedge clk);
        rst_n_w = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("w_stale_valid", 32'(id_valid_w), 32'd0);
        chk("w_stale_req", 32'(req_w), 32'd1);
        chk("w_stale_addr", addr_w, 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
